// File: rtl/ad5543_sched_if.sv
// Stream bundle between the sample sources, the scheduler and the AD5543 serializer.
// master is the scheduler's view; slave is the view of whatever sits around it.
interface ad5543_sched_if #(
  parameter int DW  = 16,
  parameter int NCH = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    s_axis_tvalid;
  logic [NCH-1:0]    s_axis_tready;
  logic [NCH*DW-1:0] s_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [CW-1:0]     m_axis_tid;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tid
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tid
  );
endinterface

// File: rtl/ad5543_sched.sv
// Paced round-robin scheduler: one slot every RATE_DIV clocks, one granted
// source word per slot forwarded to the AD5543 serializer stream.
module ad5543_sched #(
  parameter int DW       = 16,
  parameter int NCH      = 4,
  parameter int RATE_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  ad5543_sched_if.master       bus,
  output logic                 underrun,
  output logic                 overrun,
  output logic [15:0]          miss_cnt
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RW = $clog2(RATE_DIV);

  typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;

  state_t        state;
  logic [RW-1:0] rate_cnt;
  logic          tick;
  logic [CW-1:0] last_grant;
  logic [CW-1:0] grant;
  logic          any_vld;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Rotating priority: search starts just after the previous winner.
  always_comb begin
    int idx;
    grant   = '0;
    any_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last_grant) + k) % NCH;
      if (!any_vld && bus.s_axis_tvalid[idx]) begin
        any_vld = 1'b1;
        grant   = CW'(idx);
      end
    end
  end

  always_comb begin
    bus.s_axis_tready = '0;
    if (state == GRANT && en && any_vld)
      bus.s_axis_tready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_cnt <= '0;
      tick     <= 1'b0;
    end else if (!en) begin
      rate_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= (rate_cnt == RW'(RATE_DIV - 1));
      rate_cnt <= (rate_cnt == RW'(RATE_DIV - 1)) ? '0 : rate_cnt + RW'(1);
    end
  end

  // Flag updates are written after clr so a coincident event survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      last_grant        <= CW'(NCH - 1);
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tid    <= '0;
      underrun          <= 1'b0;
      overrun           <= 1'b0;
      miss_cnt          <= '0;
    end else begin
      if (clr) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
        miss_cnt <= '0;
      end
      if (tick && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick)
            state <= GRANT;
        end
        GRANT: begin
          state <= IDLE;
          if (en && any_vld) begin
            bus.m_axis_tdata  <= bus.s_axis_tdata[int'(grant)*DW +: DW];
            bus.m_axis_tid    <= grant;
            bus.m_axis_tvalid <= 1'b1;
            last_grant        <= grant;
            state             <= SEND;
          end else if (en) begin
            underrun <= 1'b1;
            miss_cnt <= clr ? 16'd1 : sat_inc(miss_cnt);
          end
        end
        SEND: begin
          if (bus.m_axis_tready) begin
            bus.m_axis_tvalid <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ad5543_sched.sv
// Bench for ad5543_sched: randomized sources and sink against a slot-level
// reference model of the scheduler.
module tb_ad5543_sched;
  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int RD  = 8;
  localparam int CW  = 2;
  localparam int VW  = 1 + DW + CW + 1 + 1 + 16 + NCH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        underrun, overrun;
  logic [15:0] miss_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ad5543_sched_if #(.DW(DW), .NCH(NCH)) bus ();

  ad5543_sched #(.DW(DW), .NCH(NCH), .RATE_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .bus(bus),
    .underrun(underrun), .overrun(overrun), .miss_cnt(miss_cnt)
  );

  // Source / sink stimulus state
  logic [NCH-1:0] src_en = '0;
  logic [NCH-1:0] src_vld = '0;
  logic [DW-1:0]  src_data [NCH];
  int             vprob = 100;
  bit             fixed_pat = 1'b0;
  logic           mrdy = 1'b0;

  // Reference model: slot-level view of the scheduler
  int             run_k;
  bit             m_tick, m_slot, m_vld, m_under, m_over;
  logic [DW-1:0]  m_data;
  int             m_tid, m_last, m_miss;
  logic [NCH-1:0] exp_rdy;

  function automatic int rr_pick(input int last, input logic [NCH-1:0] v);
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (last + k) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid,
            underrun, overrun, miss_cnt, bus.s_axis_tready};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_vld, m_data, CW'(m_tid), m_under, m_over, m_miss[15:0], exp_rdy};
  endfunction

  task automatic model_reset();
    run_k = 0; m_tick = 0; m_slot = 0; m_vld = 0; m_data = '0;
    m_tid = 0; m_last = NCH - 1; m_under = 0; m_over = 0; m_miss = 0;
  endtask

  // Called at the falling edge: refresh sources, apply inputs, predict tready.
  task automatic drive();
    int g;
    for (int i = 0; i < NCH; i++) begin
      if (src_en[i] && !src_vld[i] && $urandom_range(0, 99) < vprob) begin
        src_vld[i]  = 1'b1;
        src_data[i] = fixed_pat ? DW'(16'h1000 + i) : DW'($urandom);
      end
    end
    bus.s_axis_tvalid = src_vld;
    for (int i = 0; i < NCH; i++) bus.s_axis_tdata[i*DW +: DW] = src_data[i];
    bus.m_axis_tready = mrdy;
    g = rr_pick(m_last, src_vld);
    exp_rdy = '0;
    if (rst_n && m_slot && en && g >= 0) exp_rdy[g] = 1'b1;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic step();
    int g, pop, new_k;
    bit busy, nxt_slot, nxt_tick;
    pop = -1;
    if (!rst_n) begin
      model_reset();
    end else begin
      g        = rr_pick(m_last, src_vld);
      busy     = m_slot || m_vld;
      nxt_slot = m_tick && !busy;
      new_k    = en ? run_k + 1 : 0;
      nxt_tick = en && new_k > 0 && (new_k % RD) == 0;
      if (clr) begin m_under = 0; m_over = 0; m_miss = 0; end
      if (m_tick && busy) m_over = 1;
      if (m_vld && mrdy) m_vld = 0;
      if (m_slot && en) begin
        if (g >= 0) begin
          m_vld = 1; m_data = src_data[g]; m_tid = g; m_last = g; pop = g;
        end else begin
          m_under = 1;
          if (m_miss < 65535) m_miss++;
        end
      end
      m_slot = nxt_slot; m_tick = nxt_tick; run_k = new_k;
    end
    @(posedge clk);
    if (pop >= 0) src_vld[pop] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0; en = 0; clr = 0; src_en = '0; mrdy = 0;
    for (int i = 0; i < NCH; i++) src_data[i] = '0;
    repeat (3) step();
    drive(); #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++; $display("FAIL reset_state got=%h want=0", dut_vec());
    end
    rst_n = 1;
    step();
    drive(); #1;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_release got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_rotation();
    int tids[$];
    int gcyc[$];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    src_en = '1; fixed_pat = 1; vprob = 100; mrdy = 1; en = 1;
    for (int c = 0; c < 5 * RD + 4; c++) begin
      drive(); #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL rotation_cyc%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      if (|bus.s_axis_tready) gcyc.push_back(c);
      if (bus.m_axis_tvalid) begin
        tids.push_back(int'(bus.m_axis_tid));
        checks++;
        if (bus.m_axis_tdata !== DW'(16'h1000 + int'(bus.m_axis_tid))) begin
          failures++; $display("FAIL rotation_word got=%h want=%h", bus.m_axis_tdata, 16'h1000 + int'(bus.m_axis_tid));
        end
      end
      step();
    end
    checks++;
    if (tids.size() < 5) begin
      failures++; $display("FAIL rotation_count got=%0d want>=5", tids.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (tids[j] != exp_seq[j]) begin
          failures++; $display("FAIL rotation_tid%0d got=%0d want=%0d", j, tids[j], exp_seq[j]);
        end
      end
    end
    for (int j = 1; j < gcyc.size(); j++) begin
      checks++;
      if (gcyc[j] - gcyc[j-1] != RD) begin
        failures++; $display("FAIL grant_spacing got=%0d want=%0d", gcyc[j] - gcyc[j-1], RD);
      end
    end
  endtask

  task automatic test_sparse();
    int tids[$];
    src_en = 4'b1010; src_vld &= src_en; fixed_pat = 0; vprob = 100; mrdy = 1; en = 1;
    for (int c = 0; c < 5 * RD; c++) begin
      drive(); #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL sparse_cyc%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      checks++;
      if (bus.s_axis_tready[0] || bus.s_axis_tready[2]) begin
        failures++; $display("FAIL sparse_ready got=%b want=0x0x", bus.s_axis_tready);
      end
      if (bus.m_axis_tvalid) tids.push_back(int'(bus.m_axis_tid));
      step();
    end
    checks++;
    if (tids.size() < 4) begin
      failures++; $display("FAIL sparse_count got=%0d want>=4", tids.size());
    end
    for (int j = 0; j < tids.size(); j++) begin
      checks++;
      if ((tids[j] != 1 && tids[j] != 3) || (j > 0 && tids[j] == tids[j-1])) begin
        failures++; $display("FAIL sparse_tid%0d got=%0d want=alternating 1/3", j, tids[j]);
      end
    end
  endtask

  task automatic test_random();
    fixed_pat = 0; vprob = 40; en = 1;
    for (int c = 0; c < 300; c++) begin
      if (c % 16 == 0) src_en = NCH'($urandom);
      mrdy = ($urandom_range(0, 99) < 70);
      drive(); #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_cyc%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      step();
    end
  endtask

  task automatic test_underrun_clr();
    int slots, guard;
    src_en = '0; src_vld = '0; mrdy = 1; en = 1; clr = 1;
    drive(); #1; step();
    clr = 0;
    slots = 0; guard = 0;
    while (slots < 3 && guard < 60) begin
      drive(); #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL underrun_cyc got=%h want=%h", dut_vec(), exp_vec());
      end
      if (m_slot) slots++;
      step(); guard++;
    end
    drive(); #1;
    checks++;
    if (underrun !== 1'b1 || miss_cnt !== 16'd3) begin
      failures++; $display("FAIL underrun_3 got=%b/%0d want=1/3", underrun, miss_cnt);
    end
    clr = 1; drive(); #1; step(); clr = 0;
    drive(); #1;
    checks++;
    if (underrun !== 1'b0 || miss_cnt !== 16'd0) begin
      failures++; $display("FAIL clr_flags got=%b/%0d want=0/0", underrun, miss_cnt);
    end
    guard = 0;
    while (!m_slot && guard < 20) begin step(); drive(); #1; guard++; end
    clr = 1; drive(); #1; step(); clr = 0;
    drive(); #1;
    checks++;
    if (underrun !== 1'b1 || miss_cnt !== 16'd1) begin
      failures++; $display("FAIL clr_vs_event got=%b/%0d want=1/1", underrun, miss_cnt);
    end
  endtask

  task automatic test_overrun();
    int guard;
    logic [DW-1:0] held;
    src_en = '1; fixed_pat = 0; vprob = 100; mrdy = 1; en = 1; clr = 1;
    drive(); #1; step(); clr = 0;
    guard = 0;
    while (!m_vld && guard < 30) begin drive(); #1; step(); guard++; end
    mrdy = 0;
    held = m_data;
    for (int c = 0; c < 20; c++) begin
      drive(); #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL overrun_cyc%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      checks++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== held || |bus.s_axis_tready) begin
        failures++; $display("FAIL overrun_hold got=%b/%h want=1/%h", bus.m_axis_tvalid, bus.m_axis_tdata, held);
      end
      step();
    end
    mrdy = 1;
    drive(); #1;
    checks++;
    if (overrun !== 1'b1 || bus.m_axis_tvalid !== 1'b1) begin
      failures++; $display("FAIL overrun_flag got=%b/%b want=1/1", overrun, bus.m_axis_tvalid);
    end
    step();
    drive(); #1;
    checks++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      failures++; $display("FAIL overrun_single_word got=%b want=0", bus.m_axis_tvalid);
    end
  endtask

  task automatic test_en_drop();
    int guard, seen;
    src_en = '1; vprob = 100; mrdy = 0; en = 1;
    guard = 0;
    while (!m_vld && guard < 30) begin drive(); #1; step(); guard++; end
    en = 0;
    repeat (3) begin drive(); #1; step(); end
    mrdy = 1;
    drive(); #1;
    checks++;
    if (bus.m_axis_tvalid !== 1'b1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL en_drop_word got=%h want=%h", dut_vec(), exp_vec());
    end
    step();
    for (int c = 0; c < 20; c++) begin
      drive(); #1;
      checks++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== '0) begin
        failures++; $display("FAIL en_off_idle got=%b/%b want=0/0", bus.m_axis_tvalid, bus.s_axis_tready);
      end
      step();
    end
    en = 1; seen = -1;
    for (int c = 0; c < 30 && seen < 0; c++) begin
      drive(); #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL en_resume_cyc%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      if (|bus.s_axis_tready) seen = c;
      step();
    end
    checks++;
    if (seen != RD + 1) begin
      failures++; $display("FAIL en_resume_latency got=%0d want=%0d", seen, RD + 1);
    end
  endtask

  task automatic test_async_reset();
    int guard, first_tid;
    src_en = '1; vprob = 100; mrdy = 0; en = 1;
    guard = 0;
    while (!m_vld && guard < 30) begin drive(); #1; step(); guard++; end
    drive(); #1;
    checks++;
    if (bus.m_axis_tvalid !== 1'b1) begin
      failures++; $display("FAIL areset_pre got=%b want=1", bus.m_axis_tvalid);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++; $display("FAIL areset_immediate got=%h want=0", dut_vec());
    end
    model_reset();
    step(); step();
    rst_n = 1; mrdy = 1; first_tid = -1;
    for (int c = 0; c < 2 * RD; c++) begin
      drive(); #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL areset_after_cyc%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      if (bus.m_axis_tvalid && first_tid < 0) first_tid = int'(bus.m_axis_tid);
      step();
    end
    checks++;
    if (first_tid != 0) begin
      failures++; $display("FAIL areset_first_grant got=%0d want=0", first_tid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_sparse();
    test_random();
    test_underrun_clr();
    test_overrun();
    test_en_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
